// File: rtl/uart_rx_os_if.sv
// Serial-line side of the oversampling UART receiver: the RxD pin plus the
// received payload, its completion strobe, error flags and busy indication.
interface uart_rx_os_if #(
  parameter int DATA_BITS = 8
);
  logic                 RxD;
  logic [DATA_BITS-1:0] RxData;
  logic                 valid_rx;
  logic                 Parity_error;
  logic                 Stop_error;
  logic                 rx_busy;

  modport master (output RxD, input RxData, valid_rx, Parity_error, Stop_error, rx_busy);
  modport slave  (input RxD, output RxData, valid_rx, Parity_error, Stop_error, rx_busy);
endinterface

// File: rtl/uart_rx_os.sv
// UART receiver with 16x oversampling, 3-sample mid-bit majority vote,
// optional parity check and stop-bit check; one-cycle valid strobe per frame.
//
// state  | meaning
// IDLE   | waiting for a high-to-low edge on the synchronized line
// START  | verifying the start bit; a high majority is treated as a glitch
// DATA   | collecting DATA_BITS payload bits, LSB first
// PARITY | capturing the parity bit
// STOP   | deciding the stop bit at mid-bit and publishing the frame
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic         clk,
  input  logic         reset,
  uart_rx_os_if.slave  bus
);
  localparam int DIV   = CLK_FREQ / (BAUD_RATE * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_rx_meta, r_rxs, r_rxs_prev;
  logic [DIV_W-1:0]     r_div, w_div_nxt;
  logic [3:0]           r_s, w_s_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic [1:0]           r_smp, w_smp_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_pbit, w_pbit_nxt;
  logic [DATA_BITS-1:0] r_data, w_data_nxt;
  logic                 r_valid, w_valid_nxt;
  logic                 r_perr, w_perr_nxt;
  logic                 r_serr, w_serr_nxt;
  logic                 r_busy;
  logic                 w_tick, w_fall, w_maj, w_exp_par;

  assign w_tick    = (r_div == '0);
  assign w_fall    = r_rxs_prev & ~r_rxs;
  // samples from s=7 and s=8 are stored; the s=9 sample is the live line
  assign w_maj     = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_rxs) | (r_smp[1] & r_rxs);
  assign w_exp_par = (^r_shift) ^ (PARITY_ODD != 0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta  <= 1'b1;
      r_rxs      <= 1'b1;
      r_rxs_prev <= 1'b1;
      r_state    <= IDLE;
      r_div      <= '0;
      r_s        <= '0;
      r_idx      <= '0;
      r_smp      <= '0;
      r_shift    <= '0;
      r_pbit     <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_perr     <= 1'b0;
      r_serr     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_rx_meta  <= bus.RxD;
      r_rxs      <= r_rx_meta;
      r_rxs_prev <= r_rxs;
      r_state    <= w_state_nxt;
      r_div      <= w_div_nxt;
      r_s        <= w_s_nxt;
      r_idx      <= w_idx_nxt;
      r_smp      <= w_smp_nxt;
      r_shift    <= w_shift_nxt;
      r_pbit     <= w_pbit_nxt;
      r_data     <= w_data_nxt;
      r_valid    <= w_valid_nxt;
      r_perr     <= w_perr_nxt;
      r_serr     <= w_serr_nxt;
      r_busy     <= (w_state_nxt != IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = w_tick ? DIV_W'(DIV - 1) : r_div - 1'b1;
    w_s_nxt     = w_tick ? r_s + 4'd1 : r_s;
    w_idx_nxt   = r_idx;
    w_smp_nxt   = r_smp;
    w_shift_nxt = r_shift;
    w_pbit_nxt  = r_pbit;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_perr_nxt  = r_perr;
    w_serr_nxt  = r_serr;
    if (w_tick && r_s == 4'd7) w_smp_nxt[0] = r_rxs;
    if (w_tick && r_s == 4'd8) w_smp_nxt[1] = r_rxs;
    unique case (r_state)
      IDLE: begin
        w_s_nxt = '0;
        if (w_fall) begin
          w_state_nxt = START;
          w_div_nxt   = DIV_W'(DIV - 1);
        end
      end
      START: begin
        if (w_tick && r_s == 4'd9 && w_maj) begin
          w_state_nxt = IDLE;
        end else if (w_tick && r_s == 4'd15) begin
          w_state_nxt = DATA;
          w_idx_nxt   = '0;
        end
      end
      DATA: begin
        if (w_tick && r_s == 4'd9) w_shift_nxt = {w_maj, r_shift[DATA_BITS-1:1]};
        if (w_tick && r_s == 4'd15) begin
          if (r_idx == IDX_W'(DATA_BITS - 1)) w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
          else                                w_idx_nxt   = r_idx + 1'b1;
        end
      end
      PARITY: begin
        if (w_tick && r_s == 4'd9)  w_pbit_nxt  = w_maj;
        if (w_tick && r_s == 4'd15) w_state_nxt = STOP;
      end
      STOP: begin
        // leaving at mid-stop leaves half a bit of slack to catch the next start edge
        if (w_tick && r_s == 4'd9) begin
          w_data_nxt  = r_shift;
          w_perr_nxt  = (PARITY_EN != 0) && (r_pbit != w_exp_par);
          w_serr_nxt  = ~w_maj;
          w_valid_nxt = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.RxData       = r_data;
  assign bus.valid_rx     = r_valid;
  assign bus.Parity_error = r_perr;
  assign bus.Stop_error   = r_serr;
  assign bus.rx_busy      = r_busy;
endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: directed scenarios plus random frames,
// with a scoreboard queue of expected frames checked by an independent monitor.
module tb_uart_rx_os;
  localparam int DB   = 8;
  localparam int CLKF = 1_280_000;
  localparam int BAUD = 10_000;
  localparam int PEN  = 1;
  localparam int PODD = 0;
  localparam int DIV  = CLKF / (BAUD * 16);
  localparam int BIT  = DIV * 16;
  localparam int LAT  = ((1 + DB + PEN) * 16 + 10) * DIV + 3;

  typedef struct {
    logic [DB-1:0] data;
    logic          perr;
    logic          serr;
    int            t0;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb_q[$];
  logic [DB-1:0] m_data = '0;
  logic          m_perr = 1'b0;
  logic          m_serr = 1'b0;
  logic          prev_valid = 1'b0;

  uart_rx_os_if #(.DATA_BITS(DB)) bus ();

  uart_rx_os #(
    .DATA_BITS(DB), .CLK_FREQ(CLKF), .BAUD_RATE(BAUD),
    .PARITY_EN(PEN), .PARITY_ODD(PODD)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic check_hold(input string tag);
    check({tag, "_data"}, 64'(bus.RxData), 64'(m_data));
    check({tag, "_perr"}, 64'(bus.Parity_error), 64'(m_perr));
    check({tag, "_serr"}, 64'(bus.Stop_error), 64'(m_serr));
  endtask

  // Drives one frame; abort_bit >= 0 stops halfway through that frame bit.
  task automatic send_frame(input logic [DB-1:0] d, input logic bad_par, input logic stop_v,
                            input int bclk, input int abort_bit, input logic expect_it);
    logic [DB+2:0] fb;
    exp_t e;
    fb[0]      = 1'b0;
    fb[DB:1]   = d;
    fb[DB+1]   = (^d) ^ PODD[0] ^ bad_par;
    fb[DB+2]   = stop_v;
    if (expect_it) begin
      e.data = d; e.perr = bad_par; e.serr = ~stop_v; e.t0 = cyc;
      sb_q.push_back(e);
      m_data = d; m_perr = bad_par; m_serr = ~stop_v;
    end
    for (int i = 0; i < DB + 3; i++) begin
      bus.RxD = fb[i];
      if (i == abort_bit) begin
        repeat (bclk / 2) @(negedge clk);
        return;
      end
      repeat (bclk) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    bus.RxD = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!reset && bus.valid_rx) begin
      exp_t e;
      check("strobe_one_cycle", 64'(prev_valid), 64'(0));
      n_checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_strobe: got valid_rx with RxData %0h, expected no strobe", bus.RxData);
      end else begin
        n_pass++;
        e = sb_q.pop_front();
        check("rx_data", 64'(bus.RxData), 64'(e.data));
        check("parity_error", 64'(bus.Parity_error), 64'(e.perr));
        check("stop_error", 64'(bus.Stop_error), 64'(e.serr));
        check("busy_at_strobe", 64'(bus.rx_busy), 64'(0));
        check_range("latency", cyc - e.t0, LAT - DIV, LAT + DIV);
      end
    end
    prev_valid = bus.valid_rx;
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded 95000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    int bclk, gap;
    logic [DB-1:0] d;
    logic bp, sv;

    reset   = 1'b1;
    bus.RxD = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(bus.valid_rx), 64'(0));
    check("rst_busy", 64'(bus.rx_busy), 64'(0));
    check_hold("rst");
    reset = 1'b0;
    idle(40);

    send_frame(8'hA5, 1'b0, 1'b1, BIT, -1, 1'b1);
    idle(2 * BIT);
    send_frame(8'h3C, 1'b1, 1'b1, BIT, -1, 1'b1);
    idle(BIT);
    send_frame(8'h01, 1'b0, 1'b1, BIT, -1, 1'b1);
    idle(BIT);

    // stop bit low, then a held-low break must not retrigger
    send_frame(8'h7E, 1'b0, 1'b0, BIT, -1, 1'b1);
    repeat (3 * BIT) @(negedge clk);
    check("break_busy", 64'(bus.rx_busy), 64'(0));
    check_hold("break");
    idle(BIT);
    send_frame(8'h81, 1'b0, 1'b1, BIT, -1, 1'b1);
    idle(2 * BIT);

    bus.RxD = 1'b0;
    repeat (BIT * 3 / 8) @(negedge clk);
    check("glitch_busy_high", 64'(bus.rx_busy), 64'(1));
    idle(BIT);
    check("glitch_busy_low", 64'(bus.rx_busy), 64'(0));
    check_hold("glitch");

    // back-to-back at a TX rate about 1.5% fast
    send_frame(8'h00, 1'b0, 1'b1, BIT - 2, -1, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1, BIT - 2, -1, 1'b1);
    idle(2 * BIT);

    send_frame(8'h55, 1'b0, 1'b1, BIT, 5, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    bus.RxD = 1'b1;
    m_data = '0; m_perr = 1'b0; m_serr = 1'b0;
    check("midrst_valid", 64'(bus.valid_rx), 64'(0));
    check("midrst_busy", 64'(bus.rx_busy), 64'(0));
    check_hold("midrst");
    idle(12 * BIT);
    check("midrst_idle_busy", 64'(bus.rx_busy), 64'(0));
    check_hold("midrst_idle");
    send_frame(8'hC3, 1'b0, 1'b1, BIT, -1, 1'b1);
    idle(BIT);

    for (int k = 0; k < 20; k++) begin
      bclk = $urandom_range(BIT - 3, BIT + 3);
      d    = DB'($urandom);
      bp   = ($urandom_range(0, 4) == 0);
      sv   = ($urandom_range(0, 5) != 0);
      send_frame(d, bp, sv, bclk, -1, 1'b1);
      if (!sv)                           gap = $urandom_range(20, BIT);
      else if ($urandom_range(0, 2) == 0) gap = 0;
      else                               gap = $urandom_range(1, BIT);
      if (gap > 0) idle(gap);
    end

    idle(2 * BIT);
    check("pending_strobes", 64'(sb_q.size()), 64'(0));
    check("final_busy", 64'(bus.rx_busy), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
